// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the state type of the block master.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // RETRY and SPLIT are not supported by this master and count as errors
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_VAL     = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Byte address of a beat within a 16-byte block
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] beat);
        return base + {28'd0, beat, 2'b00};
    endfunction

endpackage

// File: rtl/ahb_block_master.sv
// AHB-Lite initiator moving one 128-bit block as a single INCR4 burst of
// four words. Bus outputs are registered; the host sees a req/done handshake.
module ahb_block_master
    import ahb_pkg::*;
(
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         req,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] rdata,
    output logic [31:0]  HADDR,
    output logic [31:0]  HWDATA,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [3:0]   HPROT,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic [1:0]   HRESP
);

    state_t       state_q,  state_d;
    logic [1:0]   abeat_q,  abeat_d;
    logic [1:0]   dbeat_q,  dbeat_d;
    logic         dphase_q, dphase_d;
    logic         write_q,  write_d;
    logic [31:0]  base_q,   base_d;
    logic [127:0] wdata_q,  wdata_d;
    logic [127:0] rbuf_q,   rbuf_d;
    logic [127:0] rdata_q,  rdata_d;
    logic         error_q,  error_d;
    logic         busy_q,   busy_d;
    logic [31:0]  haddr_q,  haddr_d;
    logic [31:0]  hwdata_q, hwdata_d;
    logic [1:0]   htrans_q, htrans_d;
    logic         hwrite_q, hwrite_d;
    logic [2:0]   hsize_q,  hsize_d;
    logic [2:0]   hburst_q, hburst_d;
    logic [3:0]   hprot_q,  hprot_d;
    logic         respErr;

    // Next-state logic: FSM, beat counters and the registered bus outputs.
    // Read words are collected in rbuf so rdata only changes on a clean finish.
    always_comb begin
        state_d  = state_q;
        abeat_d  = abeat_q;
        dbeat_d  = dbeat_q;
        dphase_d = dphase_q;
        write_d  = write_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        busy_d   = busy_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hprot_d  = hprot_q;

        // First cycle of a two-cycle error response from the slave
        respErr = dphase_q && !HREADY && (HRESP != HRESP_OKAY);

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    write_d  = req_write;
                    base_d   = req_addr;
                    wdata_d  = req_wdata;
                    busy_d   = 1'b1;
                    dphase_d = 1'b0;
                    if (req_addr[3:0] != 4'd0) begin
                        state_d = ST_FIN;
                        error_d = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        error_d  = 1'b0;
                        abeat_d  = 2'd0;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = HSIZE_WORD;
                        hburst_d = HBURST_INCR4;
                        hprot_d  = HPROT_VAL;
                    end
                end
            end
            ST_ADDR: begin
                if (respErr) begin
                    state_d  = ST_ERR;
                    htrans_d = HTRANS_IDLE;
                    dphase_d = 1'b0;
                    error_d  = 1'b1;
                end else if (HREADY) begin
                    if (dphase_q && !write_q) begin
                        rbuf_d[{dbeat_q, 5'd0} +: 32] = HRDATA;
                    end
                    dphase_d = 1'b1;
                    dbeat_d  = abeat_q;
                    hwdata_d = wdata_q[{abeat_q, 5'd0} +: 32];
                    if (abeat_q == 2'd3) begin
                        state_d  = ST_LAST;
                        htrans_d = HTRANS_IDLE;
                    end else begin
                        abeat_d  = abeat_q + 2'd1;
                        htrans_d = HTRANS_SEQ;
                        haddr_d  = beat_addr(base_q, abeat_q + 2'd1);
                    end
                end
            end
            ST_LAST: begin
                if (respErr) begin
                    state_d  = ST_ERR;
                    dphase_d = 1'b0;
                    error_d  = 1'b1;
                end else if (HREADY) begin
                    state_d  = ST_FIN;
                    dphase_d = 1'b0;
                    if (!write_q) begin
                        rdata_d = {HRDATA, rbuf_q[95:0]};
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            abeat_q  <= 2'd0;
            dbeat_q  <= 2'd0;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            base_q   <= 32'd0;
            wdata_q  <= 128'd0;
            rbuf_q   <= 128'd0;
            rdata_q  <= 128'd0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            haddr_q  <= 32'd0;
            hwdata_q <= 32'd0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'd0;
            hburst_q <= HBURST_SINGLE;
            hprot_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            abeat_q  <= abeat_d;
            dbeat_q  <= dbeat_d;
            dphase_q <= dphase_d;
            write_q  <= write_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            hprot_q  <= hprot_d;
        end
    end

    assign done   = (state_q == ST_FIN);
    assign error  = done && error_q;
    assign busy   = busy_q;
    assign rdata  = rdata_q;
    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = hsize_q;
    assign HBURST = hburst_q;
    assign HPROT  = hprot_q;

endmodule

// File: tb/tb_ahb_block_master.sv
// Scoreboard bench for ahb_block_master with a small behavioural AHB slave.
module tb_ahb_block_master;
    import ahb_pkg::*;

    logic         HCLK;
    logic         HRESETn;
    logic         req;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         busy;
    logic         done;
    logic         error;
    logic [127:0] rdata;
    logic [31:0]  HADDR;
    logic [31:0]  HWDATA;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic [1:0]   HRESP;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int startCnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int           lat;
        logic         err;
        logic [127:0] rd;
    } done_t;

    beat_t beatQ[$];
    done_t doneQ[$];

    // Slave model configuration, set by the stimulus before each request
    int waitBeat = -1;
    int waitCycles = 0;
    int errBeat = -1;

    logic        dpActive;
    logic [31:0] dpAddr;
    logic        dpWrite;
    int          beatIdx;
    int          waitLeft;
    logic        errSecond;

    ahb_block_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rdata     (rdata),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        case (a)
            32'h200: return 32'h1;
            32'h204: return 32'h2;
            32'h208: return 32'h3;
            32'h20C: return 32'h4;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Slave data-phase tracking: which beat is in its data phase and how
    // many wait states or error cycles it still owes
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dpActive  <= 1'b0;
            dpAddr    <= 32'd0;
            dpWrite   <= 1'b0;
            beatIdx   <= 0;
            waitLeft  <= 0;
            errSecond <= 1'b0;
        end else if (HREADY) begin
            errSecond <= 1'b0;
            dpActive  <= HTRANS[1];
            if (HTRANS[1]) begin
                dpAddr  <= HADDR;
                dpWrite <= HWRITE;
                if (HTRANS == HTRANS_NONSEQ) begin
                    beatIdx  <= 0;
                    waitLeft <= (waitBeat == 0) ? waitCycles : 0;
                end else begin
                    beatIdx  <= beatIdx + 1;
                    waitLeft <= (waitBeat == beatIdx + 1) ? waitCycles : 0;
                end
            end
        end else begin
            if (dpActive && beatIdx == errBeat) errSecond <= 1'b1;
            if (waitLeft > 0) waitLeft <= waitLeft - 1;
        end
    end

    // Slave response for the current data phase
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'd0;
        if (dpActive) begin
            if (beatIdx == errBeat) begin
                HRESP  = HRESP_ERROR;
                HREADY = errSecond;
            end else if (waitLeft > 0) begin
                HREADY = 1'b0;
            end
            if (!dpWrite) HRDATA = memRead(dpAddr);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each completed beat and each done pulse
    logic        prevStall = 1'b0;
    logic        prevErr = 1'b0;
    logic [65:0] prevBus = '0;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (prevStall) checkOutput("hold_addr_data", {HADDR, HWDATA, HTRANS}, prevBus);
            if (prevErr) checkOutput("htrans_after_err", HTRANS, HTRANS_IDLE);
            if (HTRANS[1] && HREADY) begin
                checkOutput("addr_ctrl", {HTRANS, HBURST, HSIZE, HPROT},
                            {(HADDR[3:0] == 4'd0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                             3'b011, 3'b010, 4'b0011});
            end
            if (dpActive && HREADY && HRESP == HRESP_OKAY) begin
                if (beatQ.size() == 0) begin
                    checkOutput("unexpected_beat", dpAddr, 128'hX);
                end else begin
                    beat_t b;
                    b = beatQ.pop_front();
                    checkOutput("beat_addr", {dpWrite, dpAddr}, {b.write, b.addr});
                    if (b.write) checkOutput("beat_wdata", HWDATA, b.data);
                end
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_done", done, 1'b0);
                end else begin
                    done_t d;
                    d = doneQ.pop_front();
                    checkOutput("done_latency", cycleCnt - startCnt + 1, d.lat);
                    checkOutput("done_error", error, d.err);
                    checkOutput("done_rdata", rdata, d.rd);
                    checkOutput("beats_left", beatQ.size(), 0);
                end
            end
            prevStall <= dpActive && !HREADY && HRESP == HRESP_OKAY;
            prevErr   <= dpActive && !HREADY && HRESP != HRESP_OKAY;
            prevBus   <= {HADDR, HWDATA, HTRANS};
        end else begin
            prevStall <= 1'b0;
            prevErr   <= 1'b0;
        end
    end

    task automatic issueReq(input logic wr, input logic [31:0] addr, input logic [127:0] wdata);
        @(negedge HCLK);
        req       = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge HCLK);
        #1;
        req       = 1'b0;
        startCnt  = cycleCnt;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                                 input int nBeats, input int expLat, input logic expErr,
                                 input logic [127:0] expRd, input logic idleBus);
        bit seen;
        for (int i = 0; i < nBeats; i++) begin
            beat_t b;
            b.addr  = addr + 32'(4 * i);
            b.write = wr;
            b.data  = wdata[32*i +: 32];
            beatQ.push_back(b);
        end
        begin
            done_t d;
            d.lat = expLat;
            d.err = expErr;
            d.rd  = expRd;
            doneQ.push_back(d);
        end
        issueReq(wr, addr, wdata);
        checkOutput("busy_after_accept", busy, 1'b1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge HCLK);
            if (idleBus) checkOutput("bus_idle", HTRANS, HTRANS_IDLE);
            if (done) seen = 1;
        end
        if (!seen) checkOutput("done_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge HCLK);
        checkOutput("busy_after_done", busy, 1'b0);
        waitBeat = -1;
        waitCycles = 0;
        errBeat = -1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_htrans"}, HTRANS, HTRANS_IDLE);
        checkOutput({tag, "_haddr_hwdata"}, {HADDR, HWDATA}, 64'd0);
        checkOutput({tag, "_ctrl"}, {HWRITE, HSIZE, HBURST, HPROT}, 11'd0);
        checkOutput({tag, "_host"}, {busy, done, error}, 3'd0);
        checkOutput({tag, "_rdata"}, rdata, 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit hit;
        HRESETn   = 1'b0;
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 128'd0;
        repeat (3) @(negedge HCLK);
        checkResetValues("reset");
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Zero-wait write
        applyStimulus(1'b1, 32'h100, 128'h00112233_44556677_8899AABB_CCDDEEFF,
                      4, 6, 1'b0, 128'd0, 1'b0);
        // Zero-wait read
        applyStimulus(1'b0, 32'h200, 128'd0, 4, 6, 1'b0,
                      128'h00000004_00000003_00000002_00000001, 1'b0);
        // Write with two wait states on beat 1
        waitBeat = 1;
        waitCycles = 2;
        applyStimulus(1'b1, 32'h140, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                      4, 8, 1'b0, 128'h00000004_00000003_00000002_00000001, 1'b0);
        // Read with ERROR on beat 2: only beats 0 and 1 complete, rdata kept
        errBeat = 2;
        applyStimulus(1'b0, 32'h300, 128'd0, 2, 6, 1'b1,
                      128'h00000004_00000003_00000002_00000001, 1'b0);
        // Misaligned request is rejected with no bus activity
        applyStimulus(1'b1, 32'h104, 128'h11111111_22222222_33333333_44444444,
                      0, 1, 1'b1, 128'h00000004_00000003_00000002_00000001, 1'b1);
        // Read with one wait state on the final beat
        waitBeat = 3;
        waitCycles = 1;
        applyStimulus(1'b0, 32'h210, 128'd0, 4, 7, 1'b0,
                      128'hA5A5021C_A5A50218_A5A50214_A5A50210, 1'b0);

        // Reset asserted while beat 2 is in its address phase
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.addr  = 32'h400 + 32'(4 * i);
            b.write = 1'b1;
            b.data  = (i == 0) ? 32'h0BAD0000 : 32'h0BAD0001;
            beatQ.push_back(b);
        end
        issueReq(1'b1, 32'h400, 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge HCLK);
            if (HADDR == 32'h408) hit = 1;
        end
        if (!hit) checkOutput("reach_beat2_timeout", 1'b0, 1'b1);
        #1;
        HRESETn = 1'b0;
        #1;
        checkResetValues("midburst_reset");
        @(negedge HCLK);
        beatQ.delete();
        doneQ.delete();
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Normal read after reset
        applyStimulus(1'b0, 32'h200, 128'd0, 4, 6, 1'b0,
                      128'h00000004_00000003_00000002_00000001, 1'b0);

        checkOutput("scoreboard_empty", {32'(beatQ.size()), 32'(doneQ.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
